// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit between ID/EX and EX/MEM: tracks the destinations of the
// last DEPTH instructions that left EX, picks bypass sources and raises load-use stalls.
module fwd_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2,
  parameter int LAT_W  = 2,
  parameter int CNT_W  = 16,
  parameter int FW     = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              freeze_i,
  input  logic              flush_i,
  input  logic              ex_valid_i,
  input  logic [REG_AW-1:0] ex_rs1_i,
  input  logic [REG_AW-1:0] ex_rs2_i,
  input  logic              ex_use1_i,
  input  logic              ex_use2_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_regwrite_i,
  input  logic [LAT_W-1:0]  ex_lat_i,
  output logic [FW-1:0]     fwd_a_o,
  output logic [FW-1:0]     fwd_b_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic [LAT_W-1:0]  lat;
  } entry_t;

  typedef struct packed {
    logic          hit;
    logic          ready;
    logic [FW-1:0] sel;
  } lookup_t;

  entry_t [DEPTH-1:0] sb_q;
  logic [CNT_W-1:0]   cnt_q;
  entry_t             new_entry;
  lookup_t            lk_a;
  lookup_t            lk_b;
  logic               haz_a;
  logic               haz_b;

  // Entries are visited oldest first so the youngest match is the one left standing;
  // an older ready producer therefore never hides a younger one still in flight.
  function automatic lookup_t lookup(input entry_t [DEPTH-1:0] sb,
                                     input logic [REG_AW-1:0] src);
    lookup_t r;
    r = '0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (sb[j].valid && sb[j].wr && (sb[j].rd == src) && (src != '0)) begin
        r.hit   = 1'b1;
        r.ready = (j >= int'(sb[j].lat));
        r.sel   = r.ready ? FW'(DEPTH - j) : '0;
      end
    end
    return r;
  endfunction

  // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    lk_a    = lookup(sb_q, ex_rs1_i);
    lk_b    = lookup(sb_q, ex_rs2_i);
    haz_a   = ex_use1_i & lk_a.hit & ~lk_a.ready;
    haz_b   = ex_use2_i & lk_b.hit & ~lk_b.ready;
    fwd_a_o = ex_use1_i ? lk_a.sel : '0;
    fwd_b_o = ex_use2_i ? lk_b.sel : '0;
    stall_o = ex_valid_i & ~flush_i & (haz_a | haz_b);
  end

  // A stalled or flushed instruction enters the scoreboard as a bubble.
  always_comb begin
    new_entry       = '0;
    new_entry.valid = ex_valid_i & ~flush_i & ~stall_o;
    new_entry.rd    = ex_rd_i;
    new_entry.wr    = ex_regwrite_i;
    new_entry.lat   = ex_lat_i;
  end

  // NOTE: non-blocking assignments make the shift read the pre-edge scoreboard.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sb_q  <= '0;
      cnt_q <= '0;
    end else if (!freeze_i) begin
      sb_q <= {sb_q[DEPTH-2:0], new_entry};
      if (stall_o && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: three instances (DEPTH=2, DEPTH=3, CNT_W=2) share
// stimulus; expectations are queued when driven and checked once outputs settle.
module tb_fwd_hazard_unit;

  typedef enum int {K_FA, K_FB, K_ST, K_CNT, K_FA3, K_FB3, K_ST3, K_CNT3,
                    K_FAC, K_FBC, K_STC, K_CNTC} kind_e;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       freeze = 1'b0;
  logic       flush = 1'b0;
  logic       ex_valid = 1'b0;
  logic [4:0] ex_rs1 = '0;
  logic [4:0] ex_rs2 = '0;
  logic       ex_use1 = 1'b0;
  logic       ex_use2 = 1'b0;
  logic [4:0] ex_rd = '0;
  logic       ex_regwrite = 1'b0;
  logic [1:0] ex_lat = '0;

  logic [1:0]  d2_fa, d2_fb, d3_fa, d3_fb, dc_fa, dc_fb;
  logic        d2_st, d3_st, dc_st;
  logic [15:0] d2_cnt, d3_cnt;
  logic [1:0]  dc_cnt;

  int tests = 0;
  int fails = 0;

  string tag_q[$];
  kind_e kind_q[$];
  int    val_q[$];

  always #5 clk = ~clk;

  fwd_hazard_unit #(.DEPTH(2)) u_d2 (
    .clk_i(clk), .rst_i(rst), .freeze_i(freeze), .flush_i(flush), .ex_valid_i(ex_valid),
    .ex_rs1_i(ex_rs1), .ex_rs2_i(ex_rs2), .ex_use1_i(ex_use1), .ex_use2_i(ex_use2),
    .ex_rd_i(ex_rd), .ex_regwrite_i(ex_regwrite), .ex_lat_i(ex_lat),
    .fwd_a_o(d2_fa), .fwd_b_o(d2_fb), .stall_o(d2_st), .stall_cnt_o(d2_cnt));

  fwd_hazard_unit #(.DEPTH(3)) u_d3 (
    .clk_i(clk), .rst_i(rst), .freeze_i(freeze), .flush_i(flush), .ex_valid_i(ex_valid),
    .ex_rs1_i(ex_rs1), .ex_rs2_i(ex_rs2), .ex_use1_i(ex_use1), .ex_use2_i(ex_use2),
    .ex_rd_i(ex_rd), .ex_regwrite_i(ex_regwrite), .ex_lat_i(ex_lat),
    .fwd_a_o(d3_fa), .fwd_b_o(d3_fb), .stall_o(d3_st), .stall_cnt_o(d3_cnt));

  fwd_hazard_unit #(.DEPTH(2), .CNT_W(2)) u_dc (
    .clk_i(clk), .rst_i(rst), .freeze_i(freeze), .flush_i(flush), .ex_valid_i(ex_valid),
    .ex_rs1_i(ex_rs1), .ex_rs2_i(ex_rs2), .ex_use1_i(ex_use1), .ex_use2_i(ex_use2),
    .ex_rd_i(ex_rd), .ex_regwrite_i(ex_regwrite), .ex_lat_i(ex_lat),
    .fwd_a_o(dc_fa), .fwd_b_o(dc_fb), .stall_o(dc_st), .stall_cnt_o(dc_cnt));

  function automatic int obs(input kind_e k);
    case (k)
      K_FA:    return int'(d2_fa);
      K_FB:    return int'(d2_fb);
      K_ST:    return int'(d2_st);
      K_CNT:   return int'(d2_cnt);
      K_FA3:   return int'(d3_fa);
      K_FB3:   return int'(d3_fb);
      K_ST3:   return int'(d3_st);
      K_CNT3:  return int'(d3_cnt);
      K_FAC:   return int'(dc_fa);
      K_FBC:   return int'(dc_fb);
      K_STC:   return int'(dc_st);
      K_CNTC:  return int'(dc_cnt);
      default: return -1;
    endcase
  endfunction

  task automatic check(input string tag, input int observed, input int expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic expect_val(input string tag, input kind_e k, input int v);
    tag_q.push_back(tag);
    kind_q.push_back(k);
    val_q.push_back(v);
  endtask

  // Outputs are combinational: let them settle, then retire every queued expectation.
  task automatic settle_check();
    #1;
    while (val_q.size() > 0) begin
      string t;
      kind_e k;
      int    v;
      t = tag_q.pop_front();
      k = kind_q.pop_front();
      v = val_q.pop_front();
      check(t, obs(k), v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic [1:0] lat);
    ex_valid = v;  ex_rs1 = rs1;  ex_use1 = u1;  ex_rs2 = rs2;  ex_use2 = u2;
    ex_rd = rd;    ex_regwrite = rw;  ex_lat = lat;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    // Reset state before any clock edge.
    #2;
    expect_val("rst_st", K_ST, 0);
    expect_val("rst_fa", K_FA, 0);
    expect_val("rst_fb", K_FB, 0);
    expect_val("rst_cnt", K_CNT, 0);
    settle_check();
    #5 rst = 1'b0;
    idle(1);

    // Build up five stall cycles with lat=3 producers (never forwardable at DEPTH=2).
    for (int g = 0; g < 2; g++) begin
      drive(1, 0, 0, 0, 0, 7, 1, 3);
      tick();
      drive(1, 7, 1, 0, 0, 0, 0, 0);
      expect_val("lat3_stall", K_ST, 1);
      settle_check();
      tick();
      tick();
      expect_val("lat3_release", K_ST, 0);
      expect_val("lat3_fa_rf", K_FA, 0);
      expect_val("lat3_cnt", K_CNT, 2 * (g + 1));
      expect_val("sat_cnt_mid", K_CNTC, (g == 0) ? 2 : 3);
      settle_check();
      tick();
    end
    drive(1, 0, 0, 0, 0, 7, 1, 3);
    tick();
    drive(1, 7, 1, 0, 0, 0, 0, 0);
    tick();
    expect_val("pre_rst_st", K_ST, 1);
    expect_val("pre_rst_cnt", K_CNT, 5);
    expect_val("sat_st", K_STC, 1);
    expect_val("sat_cnt", K_CNTC, 3);
    settle_check();

    // Asynchronous reset between edges, mid-stall.
    #2 rst = 1'b1;
    expect_val("async_st", K_ST, 0);
    expect_val("async_fa", K_FA, 0);
    expect_val("async_fb", K_FB, 0);
    expect_val("async_cnt", K_CNT, 0);
    expect_val("async_cntc", K_CNTC, 0);
    settle_check();
    #2 rst = 1'b0;
    idle(2);

    // ALU chain: MEM bypass then WB bypass, no stall.
    drive(1, 0, 0, 0, 0, 5, 1, 0);
    tick();
    drive(1, 5, 1, 0, 0, 0, 0, 0);
    expect_val("alu_fa_mem", K_FA, 2);
    expect_val("alu_st0", K_ST, 0);
    expect_val("alu_fa3", K_FA3, 3);
    expect_val("alu_fac", K_FAC, 2);
    settle_check();
    tick();
    drive(1, 0, 0, 5, 1, 0, 0, 0);
    expect_val("alu_fb_wb", K_FB, 1);
    expect_val("alu_fa_none", K_FA, 0);
    expect_val("alu_st1", K_ST, 0);
    expect_val("alu_fb3", K_FB3, 2);
    expect_val("alu_fbc", K_FBC, 1);
    settle_check();
    idle(3);

    // Load-use: one stall, then WB bypass.
    pulse_reset();
    drive(1, 0, 0, 0, 0, 7, 1, 1);
    tick();
    drive(1, 7, 1, 0, 0, 0, 0, 0);
    expect_val("lu_stall", K_ST, 1);
    settle_check();
    tick();
    expect_val("lu_release", K_ST, 0);
    expect_val("lu_fa_wb", K_FA, 1);
    expect_val("lu_cnt", K_CNT, 1);
    settle_check();
    idle(3);

    // Priority: the younger of two writers wins.
    drive(1, 0, 0, 0, 0, 3, 1, 0);
    tick();
    tick();
    drive(1, 3, 1, 0, 0, 0, 0, 0);
    expect_val("prio_fa", K_FA, 2);
    settle_check();
    idle(3);

    // Older ready match must not bypass a younger not-ready load.
    drive(1, 0, 0, 0, 0, 4, 1, 0);
    tick();
    drive(1, 0, 0, 0, 0, 4, 1, 1);
    tick();
    drive(1, 4, 1, 0, 0, 0, 0, 0);
    expect_val("young_stall", K_ST, 1);
    settle_check();
    tick();
    expect_val("young_fa", K_FA, 1);
    expect_val("young_st", K_ST, 0);
    settle_check();
    idle(3);

    // Masking: rd=0, regwrite=0, use=0.
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    tick();
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    expect_val("rd0_fa", K_FA, 0);
    settle_check();
    idle(3);
    drive(1, 0, 0, 0, 0, 9, 0, 0);
    tick();
    drive(1, 9, 1, 0, 0, 0, 0, 0);
    expect_val("nowr_fa", K_FA, 0);
    settle_check();
    idle(3);
    drive(1, 0, 0, 0, 0, 11, 1, 1);
    tick();
    drive(1, 11, 0, 11, 0, 0, 0, 0);
    expect_val("nouse_fa", K_FA, 0);
    expect_val("nouse_fb", K_FB, 0);
    expect_val("nouse_st", K_ST, 0);
    settle_check();
    idle(3);

    // Freeze during a load-use stall; freeze also outranks flush.
    pulse_reset();
    drive(1, 0, 0, 0, 0, 7, 1, 1);
    tick();
    drive(1, 7, 1, 0, 0, 0, 0, 0);
    expect_val("frz_st_pre", K_ST, 1);
    expect_val("frz_cnt_pre", K_CNT, 0);
    settle_check();
    freeze = 1'b1;
    repeat (3) tick();
    expect_val("frz_st_hold", K_ST, 1);
    expect_val("frz_cnt_hold", K_CNT, 0);
    settle_check();
    flush = 1'b1;
    expect_val("frz_flush_st", K_ST, 0);
    settle_check();
    tick();
    flush = 1'b0;
    expect_val("frz_sb_held", K_ST, 1);
    expect_val("frz_cnt_held", K_CNT, 0);
    settle_check();
    freeze = 1'b0;
    tick();
    expect_val("frz_release_st", K_ST, 0);
    expect_val("frz_release_fa", K_FA, 1);
    expect_val("frz_release_cnt", K_CNT, 1);
    settle_check();
    idle(3);

    // Flush of a would-stall instruction enters a bubble.
    drive(1, 0, 0, 0, 0, 7, 1, 1);
    tick();
    drive(1, 7, 1, 0, 0, 8, 1, 0);
    flush = 1'b1;
    expect_val("flush_st", K_ST, 0);
    settle_check();
    tick();
    flush = 1'b0;
    drive(1, 8, 1, 7, 1, 0, 0, 0);
    expect_val("flush_bubble_fa", K_FA, 0);
    expect_val("flush_prod_fb", K_FB, 1);
    expect_val("flush_st_after", K_ST, 0);
    expect_val("flush_cnt", K_CNT, 1);
    settle_check();
    idle(3);

    // DEPTH=3 long latency: lat=2 gives two stalls then WB-side bypass.
    pulse_reset();
    drive(1, 0, 0, 0, 0, 6, 1, 2);
    tick();
    drive(1, 6, 1, 0, 0, 0, 0, 0);
    expect_val("l2_stall0", K_ST3, 1);
    settle_check();
    tick();
    expect_val("l2_stall1", K_ST3, 1);
    settle_check();
    tick();
    expect_val("l2_release", K_ST3, 0);
    expect_val("l2_fa", K_FA3, 1);
    expect_val("l2_cnt", K_CNT3, 2);
    settle_check();
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard unit for the pipelined CPU, placed between the ID/EX and EX/MEM stages. It keeps an internal scoreboard of the destination registers of the last `DEPTH` instructions to leave EX. For each EX source operand it selects the youngest in-flight producer, and it raises `stall_o` when that producer's result is not yet forwardable (for example, load-use). The scoreboard freezes while the L1 data cache stalls the pipeline, and a saturating counter reports stall cycles.

## Interface
Parameters:
- `REG_AW`, 5: register address width.
- `DEPTH`, 2: number of post-EX stages tracked; must be ≥2. `DEPTH=2` covers MEM and WB.
- `LAT_W`, 2: width of `ex_lat_i`.
- `CNT_W`, 16: width of `stall_cnt_o`.
- `FW`, $clog2(DEPTH+1): width of the forward selects (derived).

Ports:
- `clk_i`, in, 1: clock; all state updates on the rising edge.
- `rst_i`, in, 1: asynchronous, active-high reset.
- `freeze_i`, in, 1: global pipeline freeze (cache miss); holds all state.
- `flush_i`, in, 1: kills the current EX instruction.
- `ex_valid_i`, in, 1: EX holds a real instruction.
- `ex_rs1_i` / `ex_rs2_i`, in, REG_AW: EX source registers.
- `ex_use1_i` / `ex_use2_i`, in, 1: the source is actually read.
- `ex_rd_i`, in, REG_AW: EX destination register.
- `ex_regwrite_i`, in, 1: EX instruction writes `ex_rd_i`.
- `ex_lat_i`, in, LAT_W: first scoreboard index at which the result is forwardable (0 = ALU, 1 = load).
- `fwd_a_o` / `fwd_b_o`, out, FW: operand source select.
- `stall_o`, out, 1: hold EX and earlier stages this cycle.
- `stall_cnt_o`, out, CNT_W: saturating count of stall cycles.

## Operation
- Scoreboard layout:
  - Entries 0..DEPTH-1, each holding {valid, rd, wr, lat}.
  - Entry j holds the instruction that left EX j+1 cycles ago (not counting frozen cycles).
  - Entry j is ready when j ≥ lat.
- Matching, per operand s:
  - An entry matches when valid, wr, rd==s, and rd≠0.
  - Only the youngest matching entry (lowest j) counts. An older ready match never bypasses a younger not-ready match.
- Forward select:
  - `fwd = DEPTH - j` when the youngest match j is ready.
  - `fwd = 0` (register file) when there is no match, or when `ex_use` for that operand is 0.
  - With DEPTH=2: 2'b10 = MEM, 2'b01 = WB, 2'b00 = register file.
- Stall condition:
  - `stall_o = ex_valid_i & ~flush_i & (hazA | hazB)`.
  - haz = use & youngest match exists & not ready.
  - While stalled, `fwd` of a hazarding operand is don't-care.
- Scoreboard update on each edge with `freeze_i=0`:
  - Shift: entry[j] ← entry[j-1] for j≥1; entry DEPTH-1 retires, and its result is then in the register file (write-before-read).
  - entry[0] ← {ex_valid_i & ~flush_i & ~stall_o, ex_rd_i, ex_regwrite_i, ex_lat_i}. A stalled or flushed instruction enters as a bubble.
- `freeze_i=1`: no shift and no counter change. Outputs are still computed combinationally from the held state.
- Simultaneous `freeze_i` and `flush_i`: freeze wins; the flush takes effect on the first unfrozen cycle if it is still asserted then.
- `ex_lat_i ≥ DEPTH` is legal: the producer is never forwarded, and consumers stall until it retires.
- Counter: increments on each edge where `stall_o & ~freeze_i`, and saturates at all-ones.
- Reset (asynchronous, any time, including mid-stall or mid-freeze):
  - All entries invalid, `stall_cnt_o = 0`.
  - Hence `fwd_a_o = fwd_b_o = 0` and `stall_o = 0` for matches, immediately.

## Timing
- Forward selects and `stall_o` are combinational from the current EX inputs and the registered scoreboard, with no added latency.
- The scoreboard and counter are registered and have a one-edge update latency.
- ALU-to-ALU back-to-back: zero stall cycles.
- Load-use with lat=1: exactly one stall cycle; the next cycle gives `fwd = DEPTH-1`.
- Producer with lat=L: consumers in the following cycle stall L cycles.
- Freeze cycles extend a stall without counting it.

## Test plan
- Reset mid-run:
  - Stimulus: entries valid, `stall_o=1`, `stall_cnt_o=5`, then assert `rst_i` between edges.
  - Required: `stall_o=0`, `fwd=00`, `stall_cnt_o=0` without waiting for a clock edge.
- ALU chain (DEPTH=2):
  - Stimulus: issue rd=5, lat=0; next cycle `ex_rs1_i=5`; the cycle after, `ex_rs2_i=5`.
  - Required: `fwd_a_o=2'b10`, then `fwd_b_o=2'b01`; `stall_o=0` throughout.
- Load-use:
  - Stimulus: issue rd=7, lat=1; next cycle rs1=7 with use1=1.
  - Required: `stall_o=1` for one cycle; next cycle `stall_o=0` and `fwd_a_o=2'b01`; `stall_cnt_o=1`.
- Priority and masking:
  - Two consecutive writers of rd=3, then a reader of rs1=3: `fwd_a_o=2'b10`.
  - Writer with rd=0, or with `ex_regwrite_i=0`: `fwd=00`.
  - A match with use=0 gives `fwd=00` and no stall.
- Freeze and flush:
  - Stimulus: hold `freeze_i=1` for 3 cycles during the load-use stall.
  - Required: `stall_o` stays 1, `stall_cnt_o` is unchanged, and the scoreboard is unchanged.
  - Stimulus: `flush_i=1` on a would-stall instruction.
  - Required: `stall_o=0`, and a bubble enters entry 0.
- Long latency and saturation:
  - Stimulus: DEPTH=3 with lat=2 and a consumer the next cycle.
  - Required: 2 stall cycles, then `fwd=2'b01`.
  - Stimulus: CNT_W=2 with 5 stall cycles.
  - Required: `stall_cnt_o=2'b11`.
